// File: rtl/cfu_simd_mac_pkg.sv
// Shared constants for the int8 SIMD multiply-accumulate custom function unit:
// op-codes, FSM states, default input offset and per-lane product width.
package cfu_simd_mac_pkg;

  localparam logic [6:0] OP_CLR     = 7'd1;
  localparam logic [6:0] OP_LOAD    = 7'd2;
  localparam logic [6:0] OP_SET_OFS = 7'd3;
  localparam logic [6:0] OP_MAC     = 7'd4;
  localparam logic [6:0] OP_READ    = 7'd5;
  localparam logic [6:0] OP_ADD     = 7'd6;
  localparam logic [6:0] OP_MAC4    = 7'd7;

  localparam logic signed [8:0] DEFAULT_OFS = 9'sd128;
  localparam int PROD_W = 18;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_ACC  = 2'd2,
    ST_RSP  = 2'd3
  } state_e;

endpackage

// File: rtl/cfu_simd_mac_lane.sv
// One int8 MAC lane: (sext(in) + offset) * sext(filt), registered while enabled.
module cfu_simd_lane
  import cfu_simd_mac_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_en,
  input  logic signed [7:0]        i_in,
  input  logic signed [7:0]        i_filt,
  input  logic signed [8:0]        i_ofs,
  output logic signed [PROD_W-1:0] o_prod
);

  logic signed [PROD_W-1:0] w_a;
  logic signed [PROD_W-1:0] w_b;
  logic signed [PROD_W-1:0] w_p;
  logic signed [PROD_W-1:0] r_prod;

  // Operand range is at most 384 * 128, so the 18-bit product never overflows.
  assign w_a = PROD_W'(i_in) + PROD_W'(i_ofs);
  assign w_b = PROD_W'(i_filt);
  assign w_p = w_a * w_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prod <= '0;
    end else if (i_en) begin
      r_prod <= w_p;
    end
  end

  assign o_prod = r_prod;

endmodule

// File: rtl/cfu_simd_mac.sv
// Int8 SIMD MAC custom function unit with lane buffers, adder tree and handshake FSM.
// Optional macro CFU_SIMD_MAC_SAT_EN makes ACC-stage and ADD results saturate.
module cfu_simd_mac
  import cfu_simd_mac_pkg::*;
#(
  parameter int LANES = 16,
  parameter int ACC_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_payload_function_id,
  input  logic [31:0] cmd_payload_inputs_0,
  input  logic [31:0] cmd_payload_inputs_1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_payload_outputs_0
);

  localparam int WORDS = LANES / 4;
  localparam int SUM_W = PROD_W + $clog2(LANES);

  state_e                   r_state;
  state_e                   w_state_nxt;
  logic [31:0]              r_in_buf   [WORDS];
  logic [31:0]              r_filt_buf [WORDS];
  logic [31:0]              r_m4_in;
  logic [31:0]              r_m4_filt;
  logic                     r_mac4;
  logic signed [8:0]        r_ofs;
  logic signed [ACC_W-1:0]  r_acc;
  logic [31:0]              r_rsp_data;

  logic [6:0]               w_op;
  logic [2:0]               w_idx;
  logic                     w_accept;
  logic [7:0]               w_lane_in   [LANES];
  logic [7:0]               w_lane_filt [LANES];
  logic signed [PROD_W-1:0] w_prod      [LANES];
  logic signed [SUM_W-1:0]  w_sum;
  logic signed [ACC_W-1:0]  w_mac_res;
  logic signed [ACC_W-1:0]  w_add_res;

  function automatic logic signed [ACC_W-1:0] f_acc_add(input logic signed [ACC_W-1:0] a,
                                                        input logic signed [ACC_W-1:0] b);
`ifdef CFU_SIMD_MAC_SAT_EN
    logic signed [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (s[ACC_W] != s[ACC_W-1]) begin
      f_acc_add = s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      f_acc_add = s[ACC_W-1:0];
    end
`else
    f_acc_add = a + b;
`endif
  endfunction

  assign w_op      = cmd_payload_function_id[9:3];
  assign w_idx     = cmd_payload_function_id[2:0];
  assign cmd_ready = (r_state == ST_IDLE);
  assign w_accept  = cmd_valid && cmd_ready;

  // MAC4 drives lanes 0..3 from the captured command words and zeroes the rest.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    if (i < 4) begin : g_m4
      assign w_lane_in[i]   = r_mac4 ? r_m4_in[8*i +: 8]   : r_in_buf[i/4][8*(i%4) +: 8];
      assign w_lane_filt[i] = r_mac4 ? r_m4_filt[8*i +: 8] : r_filt_buf[i/4][8*(i%4) +: 8];
    end else begin : g_buf
      assign w_lane_in[i]   = r_mac4 ? 8'd0 : r_in_buf[i/4][8*(i%4) +: 8];
      assign w_lane_filt[i] = r_mac4 ? 8'd0 : r_filt_buf[i/4][8*(i%4) +: 8];
    end
    cfu_simd_lane u_lane (
      .clk    (clk),
      .reset  (reset),
      .i_en   (r_state == ST_MUL),
      .i_in   (w_lane_in[i]),
      .i_filt (w_lane_filt[i]),
      .i_ofs  (r_ofs),
      .o_prod (w_prod[i])
    );
  end

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      w_sum = w_sum + SUM_W'(w_prod[i]);
    end
  end

  assign w_mac_res = f_acc_add(r_acc, ACC_W'(w_sum));
  assign w_add_res = f_acc_add(r_acc, ACC_W'($signed(cmd_payload_inputs_0)));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = (w_op == OP_MAC || w_op == OP_MAC4) ? ST_MUL : ST_RSP;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_MUL:  w_state_nxt = ST_ACC;
      ST_ACC:  w_state_nxt = ST_RSP;
      ST_RSP: begin
        if (rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RSP;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Command execution; response data only changes on acceptance or in ACC, so it holds in RSP.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc      <= '0;
      r_ofs      <= DEFAULT_OFS;
      r_rsp_data <= 32'd0;
      r_mac4     <= 1'b0;
      r_m4_in    <= 32'd0;
      r_m4_filt  <= 32'd0;
      for (int w = 0; w < WORDS; w++) begin
        r_in_buf[w]   <= 32'd0;
        r_filt_buf[w] <= 32'd0;
      end
    end else if (w_accept) begin
      case (w_op)
        OP_CLR: begin
          r_acc      <= '0;
          r_rsp_data <= 32'd0;
          for (int w = 0; w < WORDS; w++) begin
            r_in_buf[w]   <= 32'd0;
            r_filt_buf[w] <= 32'd0;
          end
        end
        OP_LOAD: begin
          r_rsp_data <= r_acc[31:0];
          for (int w = 0; w < WORDS; w++) begin
            if (w_idx == 3'(w)) begin
              r_in_buf[w]   <= cmd_payload_inputs_0;
              r_filt_buf[w] <= cmd_payload_inputs_1;
            end
          end
        end
        OP_SET_OFS: begin
          r_ofs      <= cmd_payload_inputs_0[8:0];
          r_rsp_data <= r_acc[31:0];
        end
        OP_MAC: r_mac4 <= 1'b0;
        OP_MAC4: begin
          r_mac4    <= 1'b1;
          r_m4_in   <= cmd_payload_inputs_0;
          r_m4_filt <= cmd_payload_inputs_1;
        end
        OP_READ: r_rsp_data <= r_acc[31:0];
        OP_ADD: begin
          r_acc      <= w_add_res;
          r_rsp_data <= w_add_res[31:0];
        end
        default: r_rsp_data <= 32'd0;
      endcase
    end else if (r_state == ST_ACC) begin
      r_acc      <= w_mac_res;
      r_rsp_data <= w_mac_res[31:0];
    end
  end

  assign rsp_valid             = (r_state == ST_RSP);
  assign rsp_payload_outputs_0 = r_rsp_data;

endmodule

// File: tb/tb_cfu_simd_mac.sv
// Self-checking bench for cfu_simd_mac: vector table plus handshake, saturation and reset corners.
module tb_cfu_simd_mac;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [9:0]  fid = 10'd0;
  logic [31:0] in0 = 32'd0;
  logic [31:0] in1 = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_q [$];

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  idx;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs [40];
  int   n_vecs = 0;

  cfu_simd_mac #(.LANES(16), .ACC_W(32)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_payload_function_id (fid),
    .cmd_payload_inputs_0    (in0),
    .cmd_payload_inputs_1    (in1),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_payload_outputs_0   (rsp_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard: every completed response handshake pops one expected value.
  always @(negedge clk) begin
    if (!reset && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rsp: got 0x%08h, expected no response", rsp_data);
      end else begin
        chk("rsp_data", rsp_data, exp_q.pop_front());
      end
    end
  end

  task automatic add_vec(input logic [6:0] op, input logic [2:0] idx, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    vecs[n_vecs].op  = op;
    vecs[n_vecs].idx = idx;
    vecs[n_vecs].a   = a;
    vecs[n_vecs].b   = b;
    vecs[n_vecs].exp = exp;
    vecs[n_vecs].lat = (op == 7'd4 || op == 7'd7) ? 3 : 1;
    n_vecs++;
  endtask

  // Returns #1 after the accepting edge.
  task automatic issue(input logic [6:0] op, input logic [2:0] idx, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input bit push);
    int n;
    cmd_valid = 1'b1;
    fid = {op, idx};
    in0 = a;
    in1 = b;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
    if (push) exp_q.push_back(exp);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string name, input int exp_lat);
    int lat;
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic send(input string name, input logic [6:0] op, input logic [2:0] idx,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
                      input int lat);
    issue(op, idx, a, b, exp, 1'b1);
    wait_rsp(name, lat);
    @(posedge clk);
    #1;
  endtask

  initial begin
    add_vec(7'd5, 3'd0, 32'd0, 32'd0, 32'd0);
    for (int w = 0; w < 4; w++) add_vec(7'd2, 3'(w), 32'h80808080, 32'h01010101, 32'd0);
    add_vec(7'd4, 3'd0, 32'd0, 32'd0, 32'd0);
    add_vec(7'd3, 3'd0, 32'd0, 32'd0, 32'd0);
    for (int w = 0; w < 4; w++) add_vec(7'd2, 3'(w), 32'h02020202, 32'h03030303, 32'd0);
    add_vec(7'd4, 3'd0, 32'd0, 32'd0, 32'd96);
    add_vec(7'd4, 3'd0, 32'd0, 32'd0, 32'd192);
    add_vec(7'd5, 3'd0, 32'd0, 32'd0, 32'd192);
    add_vec(7'd6, 3'd0, 32'd8, 32'd0, 32'd200);
    add_vec(7'd6, 3'd0, 32'hFFFFFFF0, 32'd0, 32'd184);
    add_vec(7'd0, 3'd0, 32'd5, 32'd5, 32'd0);
    add_vec(7'd127, 3'd7, 32'd5, 32'd5, 32'd0);
    add_vec(7'd5, 3'd0, 32'd0, 32'd0, 32'd184);
    add_vec(7'd1, 3'd0, 32'd0, 32'd0, 32'd0);
    add_vec(7'd3, 3'd0, 32'h000001FF, 32'd0, 32'd0);
    add_vec(7'd2, 3'd2, 32'h04030201, 32'hFF000102, 32'd0);
    add_vec(7'd4, 3'd0, 32'd0, 32'd0, 32'hFFFFFFFE);
    add_vec(7'd2, 3'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    add_vec(7'd4, 3'd0, 32'd0, 32'd0, 32'hFFFFFFFC);
    add_vec(7'd3, 3'd0, 32'h00000080, 32'd0, 32'hFFFFFFFC);
    add_vec(7'd1, 3'd0, 32'd0, 32'd0, 32'd0);
    add_vec(7'd2, 3'd0, 32'h01010101, 32'h01010101, 32'd0);
    add_vec(7'd7, 3'd0, 32'h7F7F7F7F, 32'h81818181, 32'hFFFE05FC);
    add_vec(7'd4, 3'd0, 32'd0, 32'd0, 32'hFFFE0800);
    add_vec(7'd1, 3'd0, 32'd0, 32'd0, 32'd0);
    add_vec(7'd7, 3'd0, 32'h80818080, 32'h00050000, 32'd5);

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_rsp_data", rsp_data, 32'd0);

    for (int v = 0; v < n_vecs; v++) begin
      send($sformatf("vec%0d", v), vecs[v].op, vecs[v].idx, vecs[v].a, vecs[v].b,
           vecs[v].exp, vecs[v].lat);
    end

    // Back-pressure: buffers are zero after CLR, so MAC leaves acc at 5.
    rsp_ready = 1'b0;
    issue(7'd4, 3'd0, 32'd0, 32'd0, 32'd5, 1'b1);
    chk("busy_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    wait_rsp("hold", 3);
    for (int c = 0; c < 5; c++) begin
      chk("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("hold_rsp_data", rsp_data, 32'd5);
      chk("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    send("clr", 7'd1, 3'd0, 32'd0, 32'd0, 32'd0, 1);
    send("add_max", 7'd6, 3'd0, 32'h7FFFFFFF, 32'd0, 32'h7FFFFFFF, 1);
`ifdef CFU_SIMD_MAC_SAT_EN
    send("add_ovf", 7'd6, 3'd0, 32'd1, 32'd0, 32'h7FFFFFFF, 1);
`else
    send("add_ovf", 7'd6, 3'd0, 32'd1, 32'd0, 32'h80000000, 1);
`endif

    // Reset while the MAC sits in ACC: no response may appear.
    issue(7'd4, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("abort_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("abort_rsp_data", rsp_data, 32'd0);
    for (int c = 0; c < 4; c++) begin
      chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      @(posedge clk);
      #1;
    end
    send("read_after_reset", 7'd5, 3'd0, 32'd0, 32'd0, 32'd0, 1);
    send("load_idx5", 7'd2, 3'd5, 32'h01010101, 32'h01010101, 32'd0, 1);
    send("mac_after_idx5", 7'd4, 3'd0, 32'd0, 32'd0, 32'd0, 3);

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cfu_simd_mac.md
CFU_SIMD_MAC -- requirements
Module: cfu_simd_mac

Interface
REQ-001 SHALL have parameter LANES, default 16, number of int8 MAC lanes (multiple of 4, range 4..32).
REQ-002 SHALL have parameter ACC_W, default 32, accumulator and response width (32..48).
REQ-003 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports cmd_valid in 1, cmd_ready out 1, cmd_payload_function_id in 10, cmd_payload_inputs_0 in 32, cmd_payload_inputs_1 in 32; these form the command channel.
REQ-006 SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_payload_outputs_0 out 32; these form the response channel, carrying acc[31:0].

Function
REQ-007 SHALL decode op = function_id[9:3] and idx = function_id[2:0].
REQ-008 SHALL accept a command only on a cycle where cmd_valid && cmd_ready; cmd_ready = (state == IDLE).
REQ-009 SHALL implement FSM states IDLE, MUL, ACC, RSP: IDLE->MUL on accepted MAC or MAC4; IDLE->RSP on any other accepted op; MUL->ACC; ACC->RSP; RSP->IDLE when rsp_ready.
REQ-010 SHALL assert rsp_valid only in RSP and hold rsp_payload_outputs_0 stable there until the rsp_valid && rsp_ready cycle.
REQ-011 Latency from acceptance at cycle T SHALL be: rsp_valid at T+1 for single-cycle ops; rsp_valid at T+3 for MAC/MAC4.
REQ-012 op 1 CLR SHALL zero acc and both lane buffers; response 0.
REQ-013 op 2 LOAD SHALL write inputs_0 to input word idx and inputs_1 to filter word idx; response acc.
REQ-014 LOAD with idx >= LANES/4 SHALL be ignored, but SHALL still return a response.
REQ-015 op 3 SET_OFS SHALL load offset <= inputs_0[8:0], signed; response acc.
REQ-016 op 4 MAC: MUL stage SHALL register per lane p[i] = (sext(in[i]) + offset) * sext(filt[i]), an 18-bit signed value.
REQ-017 MAC: ACC stage SHALL compute acc <= acc + sext(sum p[i]), with sum width 18+clog2(LANES); response is the updated acc.
REQ-018 op 5 READ SHALL return acc unchanged.
REQ-019 op 6 ADD SHALL compute acc <= acc + sext(inputs_0); response is the updated acc.
REQ-020 op 7 MAC4 SHALL behave as MAC over 4 lanes taken from inputs_0/inputs_1 bytes, captured at acceptance; buffers are untouched.
REQ-021 Any other op SHALL respond 0 with no state change.
REQ-022 Lane i SHALL use byte i%4 of word i/4, little-endian.
REQ-023 LOAD/SET_OFS SHALL be impossible while a MAC is in flight, because cmd_ready is low; the MUL stage SHALL use buffer contents as of acceptance.
REQ-024 rsp_payload_outputs_0 SHALL be acc[31:0] when ACC_W > 32.

Reset
REQ-025 When reset is high at a clock edge: state=IDLE, rsp_valid=0, rsp_payload_outputs_0=0, acc=0, buffers=0, offset=+128.
REQ-026 Reset during MUL, ACC or RSP SHALL abort the operation with no response emitted; cmd_ready=1 on the cycle after reset deasserts.

Configuration
REQ-027 With macro CFU_SIMD_MAC_SAT_EN defined, the ACC-stage and ADD results SHALL saturate to signed ACC_W min/max.
REQ-028 Without CFU_SIMD_MAC_SAT_EN, the ACC-stage and ADD results SHALL wrap modulo 2^ACC_W.

Structure
REQ-029 Package cfu_simd_mac_pkg SHALL hold: op-code constants, the FSM state enum, the default offset (128), and the product width (18).
REQ-030 The per-lane multiply SHALL be the sub-module cfu_simd_lane (in, filt, offset -> registered product), instantiated LANES times; the adder tree and FSM SHALL live in the top.

Verification
REQ-031 Reset, then LANES=16; LOAD idx 0..3 with inputs 0x80808080 and filters 0x01010101; MAC -> response 0 (-128+128=0), rsp_valid at T+3.
REQ-032 SET_OFS 0; LOAD all input words 0x02020202 and all filter words 0x03030303; MAC twice -> responses 96, then 192.
REQ-033 MAC4 with inputs_0=0x7F7F7F7F, inputs_1=0x81818181, offset 128, acc=0 -> response 4*255*(-127) = -129540.
REQ-034 Hold rsp_ready=0 for 5 cycles -> rsp_valid and data stable, cmd_ready=0; then rsp_ready=1 -> cmd_ready=1 the next cycle.
REQ-035 ADD 0x7FFFFFFF then ADD 1, with ACC_W=32 -> 0x7FFFFFFF if SAT_EN defined, else 0x80000000.
REQ-036 Reset asserted during ACC -> no rsp_valid; READ afterwards -> 0; LOAD idx 5 at LANES=16 -> response emitted, buffers unchanged.
